// File: rtl/rs_slot_allocator.sv
// Multi-port free-slot allocator for reservation-station entries: circular queue of free
// indices with all-or-nothing multi-lane grant, multi-lane release and flush reload.
module rs_slot_allocator #(
  parameter int NUM_ENTRIES = 8,
  parameter int ALLOC_WIDTH = 2,
  parameter int FREE_WIDTH  = 2,
  parameter int TYPE        = 0,
  localparam int PW = $clog2(NUM_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [ALLOC_WIDTH-1:0]    alloc_req,
  output logic                      alloc_ready,
  output logic [ALLOC_WIDTH*PW-1:0] alloc_idx,
  input  logic [FREE_WIDTH-1:0]     free_valid,
  input  logic [FREE_WIDTH*PW-1:0]  free_idx,
  output logic [PW:0]               free_count,
  output logic                      empty,
  output logic                      overflow_err
);
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] N_C = CW'(NUM_ENTRIES);

  if (NUM_ENTRIES < 4 || (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0) begin : g_bad_depth
    $error("NUM_ENTRIES must be a power of two, at least 4");
  end
  if (ALLOC_WIDTH < 1 || ALLOC_WIDTH > 4 || ALLOC_WIDTH > NUM_ENTRIES) begin : g_bad_alloc
    $error("ALLOC_WIDTH out of range");
  end
  if (FREE_WIDTH < 1 || FREE_WIDTH > 4) begin : g_bad_free
    $error("FREE_WIDTH out of range");
  end
  if (TYPE < 0 || TYPE > 2) begin : g_bad_type
    $error("TYPE must be 0 (ALU), 1 (LSU) or 2 (BRU)");
  end

  logic [PW:0]    head_reg, tail_reg, count_reg;
  logic           overflow_reg;
  logic [PW-1:0]  q_val [NUM_ENTRIES];

  logic [CW-1:0]  n_alloc, take, held, room, n_req, n_acc;
  logic [PW:0]    count_next;
  logic [PW-1:0]  alloc_pos [ALLOC_WIDTH];
  logic [PW-1:0]  free_pos  [FREE_WIDTH];
  logic [PW-1:0]  wr_ptr    [FREE_WIDTH];
  logic [FREE_WIDTH-1:0] free_acc;
  logic           overflow_hit;

  // Compacted grant: each requesting lane takes the next queue slot after lower lanes.
  always_comb begin
    n_alloc = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      alloc_pos[k] = n_alloc[PW-1:0];
      n_alloc = n_alloc + CW'(alloc_req[k]);
    end
  end

  assign alloc_ready = rst_n && !flush && (n_alloc <= {1'b0, count_reg});
  assign take        = alloc_ready ? n_alloc : '0;
  assign held        = {1'b0, count_reg} - take;
  assign room        = N_C - held;

  // Releases beyond the remaining room are dropped from the highest lane down.
  always_comb begin
    n_req    = '0;
    n_acc    = '0;
    free_acc = '0;
    for (int k = 0; k < FREE_WIDTH; k++) begin
      free_pos[k] = n_acc[PW-1:0];
      if (free_valid[k]) begin
        n_req = n_req + CW'(1);
        if (n_acc < room) begin
          free_acc[k] = 1'b1;
          n_acc = n_acc + CW'(1);
        end
      end
    end
  end

  assign overflow_hit = (n_req != n_acc);
  assign count_next   = held[PW:0] + n_acc[PW:0];

  for (genvar gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_lane
    logic [PW-1:0] rd_ptr;
    assign rd_ptr = head_reg[PW-1:0] + alloc_pos[gi];
    assign alloc_idx[gi*PW +: PW] = (alloc_ready && alloc_req[gi]) ? q_val[rd_ptr] : '0;
  end

  for (genvar gi = 0; gi < FREE_WIDTH; gi++) begin : g_wr
    assign wr_ptr[gi] = tail_reg[PW-1:0] + free_pos[gi];
  end

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_slot
    logic [PW-1:0] slot_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= PW'(gi);
      end else if (flush) begin
        slot_reg <= PW'(gi);
      end else begin
        for (int k = 0; k < FREE_WIDTH; k++) begin
          if (free_acc[k] && wr_ptr[k] == PW'(gi)) slot_reg <= free_idx[k*PW +: PW];
        end
      end
    end
    assign q_val[gi] = slot_reg;
  end

  // Flush rebuilds the queue but keeps the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg     <= '0;
      tail_reg     <= (PW+1)'(NUM_ENTRIES);
      count_reg    <= (PW+1)'(NUM_ENTRIES);
      overflow_reg <= 1'b0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= (PW+1)'(NUM_ENTRIES);
      count_reg <= (PW+1)'(NUM_ENTRIES);
    end else begin
      head_reg  <= head_reg + take[PW:0];
      tail_reg  <= tail_reg + n_acc[PW:0];
      count_reg <= count_next;
      if (overflow_hit) overflow_reg <= 1'b1;
    end
  end

  assign free_count   = count_reg;
  assign empty        = (count_reg == '0);
  assign overflow_err = overflow_reg;
endmodule

// File: tb/tb_rs_slot_allocator.sv
// Directed bench for rs_slot_allocator (N=8, two alloc lanes, two free lanes): vector
// table plus hand sequences for wrap-around, overflow, flush and asynchronous reset.
module tb_rs_slot_allocator;
  localparam int N  = 8;
  localparam int A  = 2;
  localparam int F  = 2;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [A-1:0]  alloc_req = '0;
  logic          alloc_ready;
  logic [A*PW-1:0] alloc_idx;
  logic [F-1:0]  free_valid = '0;
  logic [F*PW-1:0] free_idx = '0;
  logic [PW:0]   free_count;
  logic          empty;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;

  rs_slot_allocator #(.NUM_ENTRIES(N), .ALLOC_WIDTH(A), .FREE_WIDTH(F), .TYPE(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .free_valid(free_valid), .free_idx(free_idx),
    .free_count(free_count), .empty(empty), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] fv;
    logic [5:0] fidx;
    logic       rdy;
    logic [5:0] idx;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [14];
  int   mq[$];
  int   outst[$];

  initial begin
    // alloc_idx/free_idx packed as {lane1, lane0}; cnt is free_count before the edge.
    vecs[0]  = '{2'b11, 2'b00, 6'd0,  1'b1, 6'd8,  4'd8};
    vecs[1]  = '{2'b00, 2'b00, 6'd0,  1'b1, 6'd0,  4'd6};
    vecs[2]  = '{2'b10, 2'b00, 6'd0,  1'b1, 6'd16, 4'd6};
    vecs[3]  = '{2'b01, 2'b01, 6'd1,  1'b1, 6'd3,  4'd5};
    vecs[4]  = '{2'b11, 2'b11, 6'd24, 1'b1, 6'd44, 4'd5};
    vecs[5]  = '{2'b11, 2'b00, 6'd0,  1'b1, 6'd62, 4'd5};
    vecs[6]  = '{2'b11, 2'b00, 6'd0,  1'b1, 6'd1,  4'd3};
    vecs[7]  = '{2'b11, 2'b00, 6'd0,  1'b0, 6'd0,  4'd1};
    vecs[8]  = '{2'b00, 2'b00, 6'd0,  1'b1, 6'd0,  4'd1};
    vecs[9]  = '{2'b01, 2'b00, 6'd0,  1'b1, 6'd3,  4'd1};
    vecs[10] = '{2'b01, 2'b01, 6'd5,  1'b0, 6'd0,  4'd0};
    vecs[11] = '{2'b01, 2'b00, 6'd0,  1'b1, 6'd5,  4'd1};
    vecs[12] = '{2'b00, 2'b11, 6'd34, 1'b1, 6'd0,  4'd0};
    vecs[13] = '{2'b11, 2'b00, 6'd0,  1'b1, 6'd34, 4'd2};

    // Reset values while rst_n is low, with a request pending.
    alloc_req = 2'b11;
    #12;
    check("rst_ready", alloc_ready, 0);
    check("rst_idx", alloc_idx, 0);
    check("rst_count", free_count, N);
    check("rst_empty", empty, 0);
    check("rst_ovf", overflow_err, 0);
    alloc_req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      alloc_req  = vecs[i].req;
      free_valid = vecs[i].fv;
      free_idx   = vecs[i].fidx;
      #2;
      $display("vec %0d: req=%b fv=%b ready=%0d idx=%0d count=%0d", i, alloc_req, free_valid,
               alloc_ready, alloc_idx, free_count);
      check($sformatf("vec%0d_ready", i), alloc_ready, vecs[i].rdy);
      check($sformatf("vec%0d_idx", i), alloc_idx, vecs[i].idx);
      check($sformatf("vec%0d_count", i), free_count, vecs[i].cnt);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].cnt == 0);
      check($sformatf("vec%0d_ovf", i), overflow_err, 0);
      step();
    end
    alloc_req = '0; free_valid = '0; free_idx = '0;

    // Flush, then single-lane alloc/free for 20 cycles: head crosses the wrap twice.
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < N; i++) mq.push_back(i);
    for (int cyc = 0; cyc < 20; cyc++) begin
      int  exp_idx, fidx;
      bit  exp_rdy, do_free, dup;
      alloc_req = 2'b01;
      exp_rdy = (mq.size() >= 1);
      exp_idx = exp_rdy ? mq[0] : 0;
      do_free = (cyc >= 3) && (outst.size() > 0);
      fidx = do_free ? outst[0] : 0;
      free_valid = do_free ? 2'b01 : 2'b00;
      free_idx = {3'd0, 3'(fidx)};
      #2;
      $display("wrap %0d: ready=%0d idx=%0d count=%0d free=%0d/%0d", cyc, alloc_ready,
               alloc_idx, free_count, do_free, fidx);
      check("wrap_ready", alloc_ready, exp_rdy);
      check("wrap_idx", alloc_idx, exp_idx);
      check("wrap_count", free_count, mq.size());
      dup = 1'b0;
      foreach (outst[j]) if (alloc_ready && outst[j] == int'(alloc_idx[PW-1:0])) dup = 1'b1;
      check("wrap_no_dup", dup, 0);
      if (exp_rdy) begin
        void'(mq.pop_front());
        outst.push_back(exp_idx);
      end
      if (do_free) begin
        void'(outst.pop_front());
        mq.push_back(fidx);
      end
      step();
    end
    alloc_req = '0; free_valid = '0;

    // Flush with requests pending: nothing granted, queue reloaded.
    flush = 1'b1; alloc_req = 2'b11; free_valid = 2'b01; free_idx = 6'd4;
    #2;
    $display("flush: ready=%0d idx=%0d", alloc_ready, alloc_idx);
    check("flush_ready", alloc_ready, 0);
    check("flush_idx", alloc_idx, 0);
    step();
    flush = 1'b0; free_valid = '0; alloc_req = 2'b01;
    #2;
    check("postflush_count", free_count, N);
    check("postflush_idx", alloc_idx, 0);
    step();

    // count=7, two releases: lane0 (6) lands in Q[0], lane1 (5) is dropped.
    alloc_req = '0; free_valid = 2'b11; free_idx = {3'd5, 3'd6};
    #2;
    $display("overflow: count=%0d", free_count);
    check("ovf_pre_count", free_count, 7);
    step();
    free_valid = '0;
    #2;
    check("ovf_flag", overflow_err, 1);
    check("ovf_count", free_count, N);
    begin
      int exp_pairs [4];
      exp_pairs = '{17, 35, 53, 55};
      for (int i = 0; i < 4; i++) begin
        alloc_req = 2'b11;
        #2;
        $display("drain %0d: ready=%0d idx=%0d", i, alloc_ready, alloc_idx);
        check("drain_idx", alloc_idx, exp_pairs[i]);
        step();
      end
    end
    alloc_req = '0;
    #2;
    check("drain_empty", empty, 1);
    check("drain_count", free_count, 0);

    // Flush keeps the sticky overflow flag.
    flush = 1'b1;
    step();
    flush = 1'b0; alloc_req = 2'b11;
    #2;
    $display("after flush: ready=%0d idx=%0d ovf=%0d", alloc_ready, alloc_idx, overflow_err);
    check("flush2_count", free_count, N);
    check("flush2_ovf", overflow_err, 1);
    check("flush2_idx", alloc_idx, 8);
    step();

    // Asynchronous reset mid-cycle with a request pending.
    alloc_req = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    $display("async rst: ready=%0d idx=%0d count=%0d ovf=%0d", alloc_ready, alloc_idx,
             free_count, overflow_err);
    check("arst_ready", alloc_ready, 0);
    check("arst_idx", alloc_idx, 0);
    check("arst_count", free_count, N);
    check("arst_ovf", overflow_err, 0);
    check("arst_empty", empty, 0);
    @(negedge clk);
    rst_n = 1'b1;
    alloc_req = 2'b11;
    #2;
    check("rel_ready", alloc_ready, 1);
    check("rel_idx", alloc_idx, 8);
    step();
    alloc_req = '0;
    #2;
    check("rel_count", free_count, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/rs_slot_allocator.md
# rs_slot_allocator

Parametrised multi-port free-slot allocator for reservation-station entries; the next generation of the single-type free-slot list. It holds a circular queue of free RS entry indices. Each cycle it grants up to ALLOC_WIDTH entries to dispatch, all-or-nothing, and accepts up to FREE_WIDTH released entries from issue. It exports occupancy, stall and error status, and rebuilds its contents on a pipeline flush. One instance sits beside each RS type (ALU, LSU, BRU) in Decode.

## Interface
- NUM_ENTRIES, 8: RS depth; power of two, at least 4. PW = $clog2(NUM_ENTRIES).
- ALLOC_WIDTH, 2: dispatch lanes per cycle; 1..4, at most NUM_ENTRIES.
- FREE_WIDTH, 2: release lanes per cycle; 1..4.
- TYPE, 0: RS class tag (0 ALU, 1 LSU, 2 BRU); informational only, no behavioural effect.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; reload all entries as free.
- alloc_req  in  ALLOC_WIDTH  per-lane dispatch request.
- alloc_ready  out  1  all requested lanes can be granted this cycle.
- alloc_idx  out  ALLOC_WIDTH*PW  granted index per lane; lane k occupies bits [k*PW +: PW].
- free_valid  in  FREE_WIDTH  per-lane release strobe.
- free_idx  in  FREE_WIDTH*PW  released index per lane, same packing as alloc_idx.
- free_count  out  PW+1  number of free entries held.
- empty  out  1  free_count == 0.
- overflow_err  out  1  sticky; a release would exceed NUM_ENTRIES.

## Operation
- State:
  - slot queue Q[0..NUM_ENTRIES-1] of PW bits each.
  - head and tail pointers, PW+1 bits each, with the MSB used as the wrap bit.
  - count register, PW+1 bits.
- Reset (rst_n=0, asynchronous) and flush (synchronous) both load:
  - Q[i]=i, head=0, tail=NUM_ENTRIES (wrap bit set, index 0), count=NUM_ENTRIES.
  - overflow_err is cleared by reset only; flush leaves it unchanged.
- Allocation:
  - n_alloc = popcount(alloc_req).
  - alloc_ready = (n_alloc <= count) && !flush.
  - Lane k is compacted: alloc_idx[k] = Q[(head + popcount(alloc_req[k-1:0])) mod N].
  - An unrequested lane drives 0. alloc_ready=0 forces every lane to 0.
  - Dispatch uses the grant only when alloc_ready=1. When alloc_ready=0, head does not move and nothing is partially consumed.
  - On commit, head += n_alloc.
- Release:
  - Valid lanes are written in lane order to Q[(tail + popcount(free_valid[k-1:0])) mod N].
  - tail += n_free, where n_free = popcount(free_valid).
- Count: count_next = count - (alloc_ready ? n_alloc : 0) + n_free.
  - Compute in PW+2 bits.
  - If the result exceeds NUM_ENTRIES: set overflow_err, clamp count to NUM_ENTRIES, drop the excess lanes (highest lane numbers first) and do not advance tail for them.
- A release is never bypassed to an allocation in the same cycle. A freed index becomes grantable on the next cycle.
- flush has priority over allocation and release in its cycle. Those requests are discarded, and alloc_ready=0.
- The block performs no duplicate-index checking. Duplicate detection is the issue logic's responsibility.

## Timing
- Allocation is combinational: alloc_ready and alloc_idx are valid in the same cycle from registered head, Q and count plus alloc_req. There is no path from free_valid to alloc_idx.
- Pointers, count and Q update on the rising edge after the request.
- free_count, empty and overflow_err are driven directly from registers.
- Output values during and after reset:
  - alloc_ready=0 while rst_n is low.
  - alloc_idx=0, free_count=NUM_ENTRIES, empty=0, overflow_err=0.
  - On the first cycle after reset deasserts, alloc_ready=1 for any request with n_alloc <= NUM_ENTRIES.
- Wrap-around: pointer indices wrap modulo NUM_ENTRIES and the wrap bit toggles. Queue full means head index == tail index with differing wrap bits; empty means they are identical. These must agree with count.
- Reset asserted mid-operation: state returns to the reset values immediately (asynchronous). Any in-flight grant is invalid.

## Test plan
- Reset, N=8, A=2. Cycle 1: alloc_req=2'b11 -> alloc_idx={1,0}, alloc_ready=1. Cycle 2: free_count=6.
- alloc_req=2'b10 only -> lane1 receives Q[head] and lane0 drives 0; head advances by 1.
- Drain to count=1, then alloc_req=2'b11 -> alloc_ready=0, both lanes 0; count remains 1 on the next cycle.
- count=0, free_valid=2'b01 with free_idx lane0=5 plus alloc_req=1 in the same cycle -> alloc_ready=0. Next cycle: alloc_idx lane0=5, count=1.
- Allocate and free for 20 cycles, crossing the wrap twice -> indices are returned in FIFO order; free_count never exceeds 8; no index is granted twice while outstanding.
- With count=8, free_valid=2'b01 -> overflow_err=1 and count stays 8. Then flush -> count=8 and Q=0..7, with overflow_err still 1. Then pulse rst_n low -> overflow_err=0.
